// File: rtl/synth_voice_scheduler_if.sv
// -----------------------------------------------------------------------------
// synth_voice_scheduler_if
// Bundles the key bank inputs and the voice/mode/octave outputs of the voice
// scheduler.
//   pb, mode_pb, octave_pb : raw pushbuttons, 1 = pressed (driven by master)
//   voice_active           : 1 = voice v sounding
//   voice_note             : key index of voice v at [4v+3:4v]
//   mode, octave           : waveform / octave selection
//   steal_pulse            : one-cycle pulse when an oldest voice is reused
// master = button side, slave = scheduler.
// -----------------------------------------------------------------------------
interface synth_voice_scheduler_if #(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4
);
  logic [NUM_KEYS-1:0]     pb;
  logic                    mode_pb;
  logic                    octave_pb;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [4*NUM_VOICES-1:0] voice_note;
  logic [1:0]              mode;
  logic [1:0]              octave;
  logic                    steal_pulse;

  modport master (
    output pb, mode_pb, octave_pb,
    input  voice_active, voice_note, mode, octave, steal_pulse
  );

  modport slave (
    input  pb, mode_pb, octave_pb,
    output voice_active, voice_note, mode, octave, steal_pulse
  );
endinterface

// File: rtl/synth_voice_scheduler.sv
// -----------------------------------------------------------------------------
// synth_voice_scheduler
// Debounces the note keys and the mode/octave buttons, turns debounced edges
// into pending press/release events and hands one event per cycle to a voice
// allocator. Voices are ordered by age through a per-voice rank (0 = newest);
// when every voice is busy the voice of rank NUM_VOICES-1 is reused.
//   clk   : system clock
//   reset : synchronous, active low
//   bus   : slave side of synth_voice_scheduler_if (buttons in, voices out)
// -----------------------------------------------------------------------------
module synth_voice_scheduler #(
  parameter int NUM_KEYS      = 13,
  parameter int NUM_VOICES    = 4,
  parameter int SAMPLE_CYCLES = 60000
) (
  input  logic                   clk,
  input  logic                   reset,
  synth_voice_scheduler_if.slave bus
);
  localparam int RW = $clog2(NUM_VOICES);
  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int NI = NUM_KEYS + 2;       // keys, then mode, then octave
  localparam int MI = NUM_KEYS;
  localparam int OI = NUM_KEYS + 1;

  logic [NI-1:0]         sync1_q, sync2_q, samp_q, deb_q;
  logic [NI-1:0]         raw_s, agree_s, deb_d, rise_s;
  logic [NUM_KEYS-1:0]   fall_s;
  logic [CW-1:0]         cnt_q;
  logic                  tick_s;
  logic [NUM_KEYS-1:0]   pend_press_q, pend_rel_q, pend_press_d, pend_rel_d;
  logic [NUM_KEYS-1:0]   clr_s, clr_press_s, clr_rel_s;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [3:0]            note_q [NUM_VOICES];
  logic [3:0]            note_d [NUM_VOICES];
  logic [RW-1:0]         rank_q [NUM_VOICES];
  logic [RW-1:0]         rank_d [NUM_VOICES];
  logic [1:0]            mode_q, octave_q;
  logic                  steal_q, steal_d;
  logic                  sel_valid_s, sel_rel_s;
  logic [3:0]            sel_key_s;
  logic                  hold_hit_s, free_hit_s;
  logic [RW-1:0]         hold_v_s, free_v_s, old_v_s, tgt_v_s;

  assign raw_s  = {bus.octave_pb, bus.mode_pb, bus.pb};
  assign tick_s = (cnt_q == CW'(SAMPLE_CYCLES - 1));

  // A debounced bit only follows the sample when two consecutive samples agree.
  assign agree_s = ~(sync2_q ^ samp_q);
  assign deb_d   = tick_s ? ((agree_s & sync2_q) | (~agree_s & deb_q)) : deb_q;
  assign rise_s  = deb_d & ~deb_q;
  assign fall_s  = ~deb_d[NUM_KEYS-1:0] & deb_q[NUM_KEYS-1:0];

  // Event select: any pending release beats every pending press; lowest key wins.
  always_comb begin
    sel_rel_s   = |pend_rel_q;
    sel_valid_s = sel_rel_s | (|pend_press_q);
    sel_key_s   = 4'd0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      sel_key_s = (sel_rel_s ? pend_rel_q[k] : pend_press_q[k]) ? 4'(k) : sel_key_s;
    end
  end

  assign clr_s       = sel_valid_s ? ({{(NUM_KEYS-1){1'b0}}, 1'b1} << sel_key_s) : '0;
  assign clr_press_s = sel_rel_s ? '0 : clr_s;
  assign clr_rel_s   = sel_rel_s ? clr_s : '0;

  // Pending masks: drop the handled bit, add new edges; a release cancels its press.
  always_comb begin
    pend_press_d = ((pend_press_q & ~clr_press_s) | rise_s[NUM_KEYS-1:0]) & ~fall_s;
    pend_rel_d   = (pend_rel_q & ~clr_rel_s) | fall_s;
  end

  // Voice lookup: holder of the selected key, lowest free voice, oldest voice.
  always_comb begin
    hold_hit_s = 1'b0;
    hold_v_s   = '0;
    free_hit_s = 1'b0;
    free_v_s   = '0;
    old_v_s    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      hold_hit_s = hold_hit_s | (active_q[v] & (note_q[v] == sel_key_s));
      hold_v_s   = (active_q[v] && (note_q[v] == sel_key_s)) ? RW'(v) : hold_v_s;
      free_hit_s = free_hit_s | ~active_q[v];
      free_v_s   = active_q[v] ? free_v_s : RW'(v);
      old_v_s    = (active_q[v] && (rank_q[v] == RW'(NUM_VOICES - 1))) ? RW'(v) : old_v_s;
    end
    tgt_v_s = free_hit_s ? free_v_s : old_v_s;
  end

  // Voice next state: release closes the rank gap, press pushes everyone older.
  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    rank_d   = rank_q;
    steal_d  = 1'b0;
    if (sel_valid_s && sel_rel_s && hold_hit_s) begin
      active_d[hold_v_s] = 1'b0;
      rank_d[hold_v_s]   = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank_d[v] = (active_q[v] && (rank_q[v] > rank_q[hold_v_s])) ?
                    (rank_q[v] - RW'(1)) : rank_d[v];
      end
    end else if (sel_valid_s && !sel_rel_s && !hold_hit_s) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank_d[v] = (active_q[v] && (RW'(v) != tgt_v_s)) ? (rank_q[v] + RW'(1)) : rank_q[v];
      end
      active_d[tgt_v_s] = 1'b1;
      note_d[tgt_v_s]   = sel_key_s;
      rank_d[tgt_v_s]   = '0;
      steal_d           = ~free_hit_s;
    end else begin
      steal_d = 1'b0;
    end
  end

  // State registers: synchronizers, debouncer, pending events, voices, selectors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      samp_q       <= '0;
      deb_q        <= '0;
      cnt_q        <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      active_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= 4'd0;
        rank_q[v] <= '0;
      end
      mode_q       <= 2'd0;
      octave_q     <= 2'd0;
      steal_q      <= 1'b0;
    end else begin
      sync1_q      <= raw_s;
      sync2_q      <= sync1_q;
      cnt_q        <= tick_s ? '0 : (cnt_q + CW'(1));
      samp_q       <= tick_s ? sync2_q : samp_q;
      deb_q        <= deb_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      active_q     <= active_d;
      note_q       <= note_d;
      rank_q       <= rank_d;
      mode_q       <= mode_q + {1'b0, rise_s[MI]};
      octave_q     <= octave_q + {1'b0, rise_s[OI]};
      steal_q      <= steal_d;
    end
  end

  assign bus.voice_active = active_q;
  assign bus.mode         = mode_q;
  assign bus.octave       = octave_q;
  assign bus.steal_pulse  = steal_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note
    assign bus.voice_note[4*v +: 4] = note_q[v];
  end
endmodule

// File: tb/tb_synth_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_synth_voice_scheduler
// Randomized and directed stimulus for synth_voice_scheduler. A behavioural
// model (age-ordered voice list, pending-event arrays) predicts every output
// each cycle; literal checks pin both the DUT and the model at key points.
// -----------------------------------------------------------------------------
module tb_synth_voice_scheduler;
  localparam int NK = 13;
  localparam int NV = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_steal = 0;

  always #5 clk = ~clk;

  synth_voice_scheduler_if #(.NUM_KEYS(NK), .NUM_VOICES(NV)) bus ();

  synth_voice_scheduler #(.NUM_KEYS(NK), .NUM_VOICES(NV), .SAMPLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  bit [NK+1:0] m_s1, m_s2, m_samp, m_deb;
  int          m_cnt;
  bit [NK-1:0] m_ppress, m_prel;
  bit          m_active [NV];
  int          m_note [NV];
  int          m_age [$];          // front = oldest sounding voice
  int          m_mode, m_octave;
  bit          m_steal;

  function automatic int holder(int k);
    for (int v = 0; v < NV; v++) if (m_active[v] && m_note[v] == k) return v;
    return -1;
  endfunction

  function automatic logic [3:0] m_active_vec();
    logic [3:0] a;
    for (int v = 0; v < NV; v++) a[v] = m_active[v];
    return a;
  endfunction

  function automatic logic [15:0] m_note_vec();
    logic [15:0] n;
    for (int v = 0; v < NV; v++) n[4*v +: 4] = m_note[v][3:0];
    return n;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_samp = '0; m_deb = '0; m_cnt = 0;
    m_ppress = '0; m_prel = '0;
    for (int v = 0; v < NV; v++) begin m_active[v] = 1'b0; m_note[v] = 0; end
    m_age.delete();
    m_mode = 0; m_octave = 0; m_steal = 1'b0;
    m_valid = 1'b1;
  endtask

  task automatic model_step();
    bit [NK+1:0] raw, nd;
    bit tick, is_rel;
    int k, v, idx;
    raw  = {bus.octave_pb, bus.mode_pb, bus.pb};
    tick = (m_cnt == SC - 1);
    nd   = m_deb;
    if (tick) for (int i = 0; i < NK + 2; i++) if (m_s2[i] == m_samp[i]) nd[i] = m_s2[i];
    // one event this cycle, taken from what was pending before this edge
    k = -1; is_rel = 1'b0;
    for (int i = NK - 1; i >= 0; i--) if (m_prel[i]) begin k = i; is_rel = 1'b1; end
    if (k < 0) for (int i = NK - 1; i >= 0; i--) if (m_ppress[i]) k = i;
    m_steal = 1'b0;
    if (k >= 0 && is_rel) begin
      m_prel[k] = 1'b0;
      v = holder(k);
      if (v >= 0) begin
        m_active[v] = 1'b0;
        idx = 0;
        foreach (m_age[j]) if (m_age[j] == v) idx = j;
        m_age.delete(idx);
      end
    end else if (k >= 0) begin
      m_ppress[k] = 1'b0;
      if (holder(k) < 0) begin
        v = -1;
        for (int i = NV - 1; i >= 0; i--) if (!m_active[i]) v = i;
        if (v < 0) begin v = m_age.pop_front(); m_steal = 1'b1; end
        m_active[v] = 1'b1;
        m_note[v]   = k;
        m_age.push_back(v);
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (nd[i] && !m_deb[i]) m_ppress[i] = 1'b1;
      if (!nd[i] && m_deb[i]) begin m_prel[i] = 1'b1; m_ppress[i] = 1'b0; end
    end
    if (nd[NK] && !m_deb[NK])         m_mode   = (m_mode + 1) % 4;
    if (nd[NK+1] && !m_deb[NK+1])     m_octave = (m_octave + 1) % 4;
    m_deb = nd;
    if (tick) m_samp = m_s2;
    m_s2  = m_s1;
    m_s1  = raw;
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  always @(posedge clk) begin
    if (!reset) model_reset();
    else if (m_valid) model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(string name, logic [31:0] dut_v, logic [31:0] mdl_v, logic [31:0] exp);
    chk({name, " dut"}, dut_v, exp);
    chk({name, " model"}, mdl_v, exp);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc voice_active", {28'd0, bus.voice_active}, {28'd0, m_active_vec()});
      chk("cyc voice_note", {16'd0, bus.voice_note}, {16'd0, m_note_vec()});
      chk("cyc mode", {30'd0, bus.mode}, m_mode);
      chk("cyc octave", {30'd0, bus.octave}, m_octave);
      chk("cyc steal_pulse", {31'd0, bus.steal_pulse}, {31'd0, m_steal});
      if (bus.steal_pulse === 1'b1) n_steal++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap_mode();
    bus.mode_pb = 1'b1; cyc(16);
    bus.mode_pb = 1'b0; cyc(16);
  endtask

  task automatic tap_octave();
    bus.octave_pb = 1'b1; cyc(16);
    bus.octave_pb = 1'b0; cyc(16);
  endtask

  initial begin
    int s0;
    reset = 1'b0;
    bus.pb = '0; bus.mode_pb = 1'b0; bus.octave_pb = 1'b0;
    cyc(3);
    reset = 1'b1;

    // idle
    cyc(100);
    lit("idle active", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h0);
    lit("idle note", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'h0);
    chk("idle steal count", n_steal, 32'd0);

    // single key
    bus.pb[5] = 1'b1; cyc(20);
    lit("key5 active", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h1);
    lit("key5 note", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'h0005);
    bus.pb[5] = 1'b0; cyc(20);
    lit("key5 released", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h0);
    lit("key5 note kept", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'h0005);

    // fill all voices, then steal
    bus.pb[2] = 1'b1; cyc(16);
    bus.pb[7] = 1'b1; cyc(16);
    bus.pb[9] = 1'b1; cyc(16);
    bus.pb[11] = 1'b1; cyc(16);
    lit("full notes", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'hB972);
    s0 = n_steal;
    bus.pb[0] = 1'b1; cyc(16);
    lit("steal notes", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'hB970);
    chk("steal pulse count", n_steal - s0, 32'd1);
    bus.pb[2] = 1'b0; cyc(16);
    lit("stolen release", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'hF);
    bus.pb = '0; cyc(20);
    lit("all released", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h0);

    // release and two presses land in the same sample
    bus.pb[1] = 1'b1; cyc(16);
    lit("key1 note", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'hB971);
    bus.pb[1] = 1'b0; bus.pb[3] = 1'b1; bus.pb[4] = 1'b1; cyc(16);
    lit("combo active", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h3);
    lit("combo note", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'hB943);
    bus.pb = '0; cyc(20);

    // one-sample glitch, then mode/octave taps
    bus.pb[6] = 1'b1; cyc(SC);
    bus.pb[6] = 1'b0; cyc(20);
    lit("glitch ignored", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h0);
    repeat (5) tap_mode();
    lit("mode after 5", {30'd0, bus.mode}, m_mode, 32'd1);
    repeat (3) tap_octave();
    lit("octave after 3", {30'd0, bus.octave}, m_octave, 32'd3);

    // reset with voices sounding, keys held through it
    bus.pb[1] = 1'b1; bus.pb[2] = 1'b1; bus.pb[3] = 1'b1; cyc(20);
    lit("pre-reset active", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h7);
    reset = 1'b0; cyc(1);
    lit("reset active", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h0);
    lit("reset mode", {30'd0, bus.mode}, m_mode, 32'd0);
    lit("reset octave", {30'd0, bus.octave}, m_octave, 32'd0);
    reset = 1'b1; cyc(20);
    lit("held realloc active", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h7);
    lit("held realloc note", {16'd0, bus.voice_note}, {16'd0, m_note_vec()}, 32'h0321);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      int r, kk;
      r  = $urandom_range(0, 99);
      kk = $urandom_range(0, NK - 1);
      if (r < 2) begin
        reset = 1'b0; cyc($urandom_range(1, 3)); reset = 1'b1;
      end else if (r < 9) begin
        bus.mode_pb = ~bus.mode_pb;
      end else if (r < 15) begin
        bus.octave_pb = ~bus.octave_pb;
      end else begin
        bus.pb[kk] = ~bus.pb[kk];
        if (r >= 85) begin
          kk = $urandom_range(0, NK - 1);
          bus.pb[kk] = ~bus.pb[kk];
        end
      end
      cyc($urandom_range(1, 14));
    end
    bus.pb = '0; bus.mode_pb = 1'b0; bus.octave_pb = 1'b0;
    cyc(40);
    lit("final idle", {28'd0, bus.voice_active}, {28'd0, m_active_vec()}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
